bram_capture_ctrl: RTL and testbench

- Sequences sample captures into the shared BRAM from the control/status register words. Converts a software start command plus an external trigger into a stream of BRAM write cycles.
- Selects one of 2^SEL_W buffer regions.
- Reports progress back as a status word, which is wired to the register file's status input.

---
 rtl/bram_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_bram_capture_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_capture_ctrl.sv
// Capture sequencer: a start edge plus a trigger level turn input samples into BRAM writes
// at {buffer, pointer}. Optional input decimation is built when BRAM_CAPTURE_DECIM_EN is defined.
module bram_capture_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             ctrl,
   input  logic [31:0]             sel,
   input  logic                    trig,
   input  logic                    din_valid,
   input  logic [DATA_W-1:0]       din,
   output logic                    bram_we,
   output logic [SEL_W+ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0]       bram_wdata,
   output logic [31:0]             status,
   output logic                    done_irq
);

   localparam int          CW      = ADDR_W + 1;
   localparam logic [15:0] LEN_MAX = 16'((1 << ADDR_W) - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state;
   logic              ctrl0_q;
   logic              start_pulse;
   logic              abort;
   logic              do_arm;
   logic              cap_en;
   logic              accept;
   logic              last_wr;
   logic              decim_ok;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] len_clip;
   logic [ADDR_W-1:0] ptr;
   logic [SEL_W-1:0]  sel_q;
   logic              wrap_q;
   logic              done_f;
   logic              aborted_f;
   logic              wrapped_f;
   logic [CW-1:0]     count;
   logic [CW-1:0]     len_p1;
   logic              unused_bits;

   assign unused_bits = ^{sel[31:SEL_W], ctrl[15:3]};

   assign start_pulse = ctrl[0] & ~ctrl0_q;
   assign abort       = ctrl[1];
   assign len_clip    = (ctrl[31:16] > LEN_MAX) ? LEN_MAX[ADDR_W-1:0] : ctrl[ADDR_W+15:16];
   assign len_p1      = {1'b0, len_q} + CW'(1);
   // Start is honoured only when idle or finished; abort wins over a start in DONE.
   assign do_arm      = start_pulse & ((state == IDLE) | ((state == DONE) & ~abort));
   assign cap_en      = ~abort & (((state == ARMED) & trig) | (state == CAPTURE));
   assign accept      = cap_en & din_valid & decim_ok;
   assign last_wr     = (ptr == len_q);

`ifdef BRAM_CAPTURE_DECIM_EN
   logic [3:0] decim_n_q;
   logic [3:0] decim_cnt;

   // The trigger-cycle sample is always taken, so the counter is primed on that cycle.
   assign decim_ok = (state != CAPTURE) | (decim_cnt == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decim_n_q <= 4'd0;
         decim_cnt <= 4'd0;
      end else begin
         if (do_arm)
            decim_n_q <= ctrl[11:8];
         if ((state == ARMED) && trig)
            decim_cnt <= din_valid ? decim_n_q : 4'd0;
         else if ((state == CAPTURE) && din_valid)
            decim_cnt <= (decim_cnt == 4'd0) ? decim_n_q : decim_cnt - 4'd1;
      end
   end
`else
   assign decim_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ctrl0_q    <= 1'b0;
         len_q      <= '0;
         sel_q      <= '0;
         wrap_q     <= 1'b0;
         ptr        <= '0;
         count      <= '0;
         done_f     <= 1'b0;
         aborted_f  <= 1'b0;
         wrapped_f  <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         done_irq   <= 1'b0;
      end else begin
         ctrl0_q  <= ctrl[0];
         bram_we  <= 1'b0;
         done_irq <= 1'b0;

         if (do_arm) begin
            state     <= ARMED;
            len_q     <= len_clip;
            sel_q     <= sel[SEL_W-1:0];
            wrap_q    <= ctrl[2];
            ptr       <= '0;
            count     <= '0;
            done_f    <= 1'b0;
            aborted_f <= 1'b0;
            wrapped_f <= 1'b0;
         end else if (abort && (state != IDLE)) begin
            state <= IDLE;
            // Aborting a finished capture keeps its flags for software to read.
            if (state != DONE) begin
               aborted_f <= 1'b1;
               done_f    <= 1'b0;
            end
         end else if ((state == ARMED) && trig) begin
            state <= CAPTURE;
         end

         if (accept) begin
            bram_we    <= 1'b1;
            bram_addr  <= {sel_q, ptr};
            bram_wdata <= din;
            if (count != len_p1)
               count <= count + CW'(1);
            if (!last_wr) begin
               ptr <= ptr + ADDR_W'(1);
            end else if (wrap_q) begin
               ptr       <= '0;
               wrapped_f <= 1'b1;
            end else begin
               state    <= DONE;
               done_f   <= 1'b1;
               done_irq <= 1'b1;
            end
         end
      end
   end

   assign status = {16'(count), 11'd0, wrapped_f, aborted_f, done_f, state};

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed bench for bram_capture_ctrl: a vector table for basic/wrap capture and
// hand-written sequences for trigger gating, clipping, abort, reset and decimation.
module tb_bram_capture_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 2;
   localparam int AW     = SEL_W + ADDR_W;
   localparam int W      = AW + DATA_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       ctrl;
   logic [31:0]       sel;
   logic              trig;
   logic              din_valid;
   logic [DATA_W-1:0] din;
   logic              bram_we;
   logic [AW-1:0]     bram_addr;
   logic [DATA_W-1:0] bram_wdata;
   logic [31:0]       status;
   logic              done_irq;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [31:0] ctrl;
      logic [31:0] sel;
      logic        trig;
      logic        dv;
      logic [31:0] din;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] status;
      logic        irq;
   } vec_t;

   vec_t vt[$];

   bram_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .sel(sel), .trig(trig),
      .din_valid(din_valid), .din(din), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .status(status), .done_irq(done_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] c, input logic [31:0] s, input logic t,
                        input logic v, input logic [31:0] d);
      ctrl      = c;
      sel       = s;
      trig      = t;
      din_valid = v;
      din       = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] c, input logic [31:0] s, input logic t, input logic v,
                      input logic [31:0] d, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] st, input logic irq);
      vec_t r;
      r.ctrl = c; r.sel = s; r.trig = t; r.dv = v; r.din = d;
      r.we = we; r.addr = a; r.wdata = wd; r.status = st; r.irq = irq;
      vt.push_back(r);
   endtask

   task automatic push_exp(input int a, input int d);
      exp_q.push_back({AW'(a), DATA_W'(d)});
   endtask

   task automatic check_write(input string name);
      logic [W-1:0] e;
      if (bram_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected write addr 0x%0h data 0x%0h", name, bram_addr, bram_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({bram_addr, bram_wdata} !== e) begin
               errors++;
               $display("FAIL %s: got addr/data 0x%0h expected 0x%0h", name, {bram_addr, bram_wdata}, e);
            end
         end
      end
   endtask

   initial begin
      int writes;
      int irq_write;
      int bad;
      logic [AW-1:0] ea;

      reset_n = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

      // basic capture: len-1=7, buffer 2
      add(32'h0007_0000, 2, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
      add(32'h0007_0001, 2, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 0);
      for (int k = 0; k < 8; k++)
         add(32'h0007_0001, 2, k == 0, 1, 32'h100 + k, 1, 32'h800 + k, 32'h100 + k,
             (k == 7) ? 32'h0008_0007 : (((k + 1) << 16) | 2), k == 7);
      add(32'h0007_0001, 2, 0, 0, 0, 0, 0, 0, 32'h0008_0007, 0);
      // abort in DONE keeps done flag and count
      add(32'h0007_0002, 2, 0, 0, 0, 0, 0, 0, 32'h0008_0004, 0);
      // wrap mode: len-1=3, buffer 0, 10 samples
      add(32'h0003_0004, 0, 0, 0, 0, 0, 0, 0, 32'h0008_0004, 0);
      add(32'h0003_0005, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 0);
      for (int k = 0; k < 10; k++)
         add(32'h0003_0005, 0, k == 0, 1, 32'h200 + k, 1, k % 4, 32'h200 + k,
             (((k < 3) ? k + 1 : 4) << 16) | ((k >= 3) ? 32'h10 : 32'h0) | 2, 0);
      add(32'h0003_0006, 0, 0, 1, 32'h2FF, 0, 0, 0, 32'h0004_0018, 0);
      add(32'h0003_0004, 0, 0, 1, 32'h2FF, 0, 0, 0, 32'h0004_0018, 0);

      // reset state
      tick();
      tick();
      chk("rst_we", bram_we, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_wdata", bram_wdata, 0);
      chk("rst_status", status, 0);
      chk("rst_irq", done_irq, 0);
      reset_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].ctrl, vt[i].sel, vt[i].trig, vt[i].dv, vt[i].din);
         tick();
         chk($sformatf("vec%0d_we", i), bram_we, vt[i].we);
         if (vt[i].we) begin
            chk($sformatf("vec%0d_addr", i), bram_addr, vt[i].addr);
            chk($sformatf("vec%0d_wdata", i), bram_wdata, vt[i].wdata);
         end
         chk($sformatf("vec%0d_status", i), status, vt[i].status);
         chk($sformatf("vec%0d_irq", i), done_irq, vt[i].irq);
      end

      // trigger gating: valid held high, trigger 5 cycles after arming
      drive(32'h0003_0001, 1, 0, 1, 32'h500);
      tick();
      chk("gate_armed", status, 32'h0000_0001);
      chk("gate_we0", bram_we, 0);
      for (int i = 0; i < 5; i++) begin
         drive(32'h0003_0001, 1, 0, 1, 32'h501 + i);
         tick();
         chk($sformatf("gate_no_we%0d", i), bram_we, 0);
      end
      push_exp(32'h400, 32'h5A5);
      drive(32'h0003_0001, 1, 1, 1, 32'h5A5);
      tick();
      chk("gate_first_we", bram_we, 1);
      check_write("gate_first");
      drive(32'h0003_0002, 1, 0, 0, 0);
      tick();
      chk("gate_abort_status", status, 32'h0001_0008);

      // abort and trigger together while armed
      drive(32'h0003_0001, 0, 0, 0, 0);
      tick();
      chk("abtrig_armed", status, 32'h0000_0001);
      drive(32'h0003_0003, 0, 1, 1, 32'h777);
      tick();
      chk("abtrig_we", bram_we, 0);
      chk("abtrig_status", status, 32'h0000_0008);
      tick();
      chk("abtrig_we_after", bram_we, 0);

      // length clipping to 1023, with a busy start edge mid-capture
      drive(32'hFFFF_0000, 3, 0, 0, 0);
      tick();
      drive(32'hFFFF_0001, 3, 0, 0, 0);
      tick();
      chk("clip_armed", status, 32'h0000_0001);
      writes = 0;
      irq_write = -1;
      bad = 0;
      for (int cyc = 0; cyc < 1100 && irq_write < 0; cyc++) begin
         drive((cyc == 300) ? 32'hFFFF_0000 : 32'hFFFF_0001, 3, cyc == 0, 1, cyc);
         tick();
         if (bram_we) begin
            ea = {2'b11, 10'(writes)};
            if (bram_addr !== ea || bram_wdata !== 32'(writes))
               bad++;
            writes++;
         end
         if (done_irq)
            irq_write = writes;
      end
      chk("clip_writes", writes, 1024);
      chk("clip_irq_at", irq_write, 1024);
      chk("clip_addr_data_errs", bad, 0);
      chk("clip_status", status, 32'h0400_0007);
      drive(32'hFFFF_0001, 3, 0, 1, 32'h999);
      tick();
      chk("clip_no_more_we", bram_we, 0);

      // re-arm from DONE, then reset mid-capture
      drive(32'h0007_0000, 3, 0, 0, 0);
      tick();
      drive(32'h0007_0001, 3, 0, 0, 0);
      tick();
      chk("rearm_status", status, 32'h0000_0001);
      drive(32'h0007_0001, 3, 1, 1, 32'hABC);
      tick();
      chk("rstmid_pre_we", bram_we, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstmid_we", bram_we, 0);
      chk("rstmid_status", status, 0);
      chk("rstmid_irq", done_irq, 0);
      tick();
      reset_n = 1'b1;
      drive(32'h0, 0, 0, 0, 0);
      tick();
      chk("rstmid_idle", status, 0);

      // decimation N=2 (ignored without the feature)
      drive(32'h0007_0200, 0, 0, 0, 0);
      tick();
      drive(32'h0007_0201, 0, 0, 0, 0);
      tick();
`ifdef BRAM_CAPTURE_DECIM_EN
      push_exp(0, 0);
      push_exp(1, 3);
      push_exp(2, 6);
`else
      for (int k = 0; k < 8; k++)
         push_exp(k, k);
`endif
      for (int i = 0; i < 9; i++) begin
         drive(32'h0007_0201, 0, i == 0, 1, i);
         tick();
         check_write($sformatf("decim_wr%0d", i));
      end
      drive(32'h0007_0201, 0, 0, 0, 0);
      tick();
      check_write("decim_tail");
`ifdef BRAM_CAPTURE_DECIM_EN
      chk("decim_status", status, 32'h0003_0002);
`else
      chk("decim_status", status, 32'h0008_0007);
`endif
      chk("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
